// File: rtl/stopwatch_run_ctrl_if.sv
// Button/counter-facing signal bundle of the stopwatch run/lap/clear sequencer.
// The master drives the raw buttons and cnt_max; the slave is the sequencer.
interface stopwatch_run_ctrl_if #(
    parameter int unsigned LAP_DEPTH = 4
);
    localparam int unsigned IDX_W = $clog2(LAP_DEPTH);

    logic             btn_ss;
    logic             btn_lap;
    logic             btn_clr;
    logic             cnt_max;
    logic             tick;
    logic             cnt_clr;
    logic             lap_wr;
    logic [IDX_W-1:0] lap_idx;
    logic             disp_sel;
    logic [1:0]       ctrl_state;

    modport master (
        output btn_ss, btn_lap, btn_clr, cnt_max,
        input  tick, cnt_clr, lap_wr, lap_idx, disp_sel, ctrl_state
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, cnt_max,
        output tick, cnt_clr, lap_wr, lap_idx, disp_sel, ctrl_state
    );
endinterface

// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch run/lap/clear sequencer: debounced button events drive a 4-state
// mode machine that produces the count tick, counter clear, lap strobe and display select.
module stopwatch_run_ctrl #(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned LAP_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 RST,
    stopwatch_run_ctrl_if.slave  bus
);
    localparam int unsigned NBTN  = 3;
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned IDX_W = $clog2(LAP_DEPTH);
    localparam int unsigned B_SS  = 0;
    localparam int unsigned B_LAP = 1;
    localparam int unsigned B_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_PAUSE    = 2'b10,
        ST_LAP_HOLD = 2'b11
    } state_e;

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  lvl_q, lvl_d;
    logic [NBTN-1:0]  lvl_prev_q, lvl_prev_d;
    logic [NBTN-1:0]  ev_q, ev_d;
    logic [DEB_W-1:0] deb_cnt_q [NBTN];
    logic [DEB_W-1:0] deb_cnt_d [NBTN];

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
    logic             lap_wr_q, lap_wr_d;
    logic             rec_lap;
    logic             running;
    logic             at_top;
    logic             tick_c;

    assign btn_raw = {bus.btn_clr, bus.btn_lap, bus.btn_ss};

    // Button front end: synchronize, debounce, then register the rising edge of the accepted level.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        lvl_prev_d = lvl_q;
        ev_d       = lvl_q & ~lvl_prev_q;
        for (int i = 0; i < NBTN; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] + DEB_W'(1) == DEB_W'(DEB_CYCLES)) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Mode machine; the first matching rule per state wins.
    always_comb begin
        state_d = state_q;
        rec_lap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_q[B_SS]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cnt_max) begin
                    state_d = ST_PAUSE;
                end else if (ev_q[B_SS]) begin
                    state_d = ST_PAUSE;
                end else if (ev_q[B_LAP]) begin
                    state_d = ST_LAP_HOLD;
                    rec_lap = 1'b1;
                end
            end
            ST_LAP_HOLD: begin
                if (bus.cnt_max) begin
                    state_d = ST_PAUSE;
                end else if (ev_q[B_CLR]) begin
                    state_d = ST_RUN;
                end else if (ev_q[B_SS]) begin
                    state_d = ST_PAUSE;
                end else if (ev_q[B_LAP]) begin
                    rec_lap = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ev_q[B_CLR]) begin
                    state_d = ST_IDLE;
                end else if (ev_q[B_SS] && !bus.cnt_max) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Prescaler and lap index; PAUSE freezes the prescaler so resume keeps the tick phase.
    always_comb begin
        running   = (state_q == ST_RUN) || (state_q == ST_LAP_HOLD);
        at_top    = (presc_q == PRE_W'(TICK_DIV - 1));
        tick_c    = running && at_top && !bus.cnt_max;
        presc_d   = presc_q;
        lap_idx_d = lap_idx_q;
        lap_wr_d  = rec_lap;
        if (state_d == ST_IDLE) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = at_top ? '0 : presc_q + PRE_W'(1);
        end
        if (state_d == ST_IDLE) begin
            lap_idx_d = '0;
        end else if (lap_wr_q) begin
            lap_idx_d = lap_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            ev_q       <= '0;
            for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= '0;
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            lap_idx_q  <= '0;
            lap_wr_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            ev_q       <= ev_d;
            for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            presc_q    <= presc_d;
            lap_idx_q  <= lap_idx_d;
            lap_wr_q   <= lap_wr_d;
        end
    end

    assign bus.tick       = tick_c;
    assign bus.cnt_clr    = (state_q == ST_IDLE);
    assign bus.disp_sel   = (state_q == ST_LAP_HOLD);
    assign bus.ctrl_state = state_q;
    assign bus.lap_wr     = lap_wr_q;
    assign bus.lap_idx    = lap_idx_q;
endmodule
